dcache_req_arbiter: RTL and testbench
=====================================

# dcache_req_arbiter

Two-requester arbiter in front of the data cache port. It merges LSU load requests and store-buffer drain writes onto the single dcache request interface, registers the winning request, and routes the dcache ack (and load data) back to the granted requester. Loads normally win, except on a same-word hazard, where the pending store drains first so the load never reads stale data.

## Interface
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `BYTE_SEL_WIDTH`, 4: byte-select width; word offset bits = log2(BYTE_SEL_WIDTH).
- `STARVE_LIMIT`, 4: consecutive load grants allowed while a store waits (only with guard macro).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset; one clock, reset asynchronous active-low.
- `lsu2arb_addr` in ADDR_WIDTH: load address.
- `lsu2arb_req` in 1: load request, held until ack.
- `arb2lsu_rdata` out DATA_WIDTH: load data.
- `arb2lsu_ack` out 1: load complete.
- `stb2arb_addr` in ADDR_WIDTH: store address.
- `stb2arb_wdata` in DATA_WIDTH: store data.
- `stb2arb_sel_byte` in BYTE_SEL_WIDTH: store byte select.
- `stb2arb_req` in 1: store request, held until ack.
- `arb2stb_ack` out 1: store written.
- `arb2dcache_addr` out ADDR_WIDTH: registered request address.
- `arb2dcache_wdata` out DATA_WIDTH: registered write data.
- `arb2dcache_sel_byte` out BYTE_SEL_WIDTH: registered byte select.
- `arb2dcache_w_en` out 1: 1 = write (store), 0 = read (load).
- `arb2dcache_req` out 1: request valid.
- `dcache2arb_rdata` in DATA_WIDTH: read data.
- `dcache2arb_ack` in 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, LOAD_BUSY, STORE_BUSY.
- **IDLE, no request:** stay in IDLE.
- **IDLE, only one request:** grant it.
- **IDLE, both requests, load normally wins.**
  - A hazard forces the store to win instead.
  - Hazard = `lsu2arb_addr` and `stb2arb_addr` match on bits [ADDR_WIDTH-1:log2(BYTE_SEL_WIDTH)].
- **Grant action:**
  - Capture addr, wdata, sel_byte and w_en into the output registers.
  - Set `arb2dcache_req` = 1.
  - Enter LOAD_BUSY or STORE_BUSY.
  - For a load grant: wdata is zero and sel_byte is all ones.
- **BUSY states:**
  - Output registers are frozen; new requests are ignored.
  - On `dcache2arb_ack`: clear `arb2dcache_req` and return to IDLE.
- **Ack routing (combinational):**
  - `arb2lsu_ack` = ack & LOAD_BUSY.
  - `arb2stb_ack` = ack & STORE_BUSY.
  - `arb2lsu_rdata` = `dcache2arb_rdata` whenever in LOAD_BUSY, else 0.
- Requests dropped by a requester before ack are still completed by the arbiter; the ack is delivered anyway.
- Reset values:
  - All registered outputs are 0; state is IDLE.
  - `arb2lsu_ack`, `arb2stb_ack` and `arb2lsu_rdata` are 0.
- **Reset mid-transaction:** the in-flight request is abandoned, state goes to IDLE, and the requester must re-request.

## Timing
- Request sampled in IDLE at edge N → `arb2dcache_req` high after edge N, stable until ack.
- Requester ack appears in the same cycle as `dcache2arb_ack`.
- The FSM is in IDLE the cycle after ack; the next grant occurs at the following edge.
- Back-to-back throughput is therefore one transaction per (dcache latency + 1) cycles minimum.
- An ack arriving in IDLE is ignored: no requester ack, no state change.
- A request that rises in the same cycle as an ack is considered only once IDLE.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A saturating counter increments on each load grant made while `stb2arb_req` = 1.
  - It clears on any store grant.
  - When count == STARVE_LIMIT and both requests are present, the store wins.
- Not defined: no counter; stores win only on a hazard, or when no load is requesting.

## Structure
- Shared package `dcache_arb_pkg` holds:
  - The state enum `arb_state_e` (IDLE, LOAD_BUSY, STORE_BUSY).
  - A packed struct `dcache_req_t` (addr, wdata, sel_byte, w_en).
- No sub-module; the guard counter is an in-module `ifdef` block.

## Test plan
- **Load only:** load at 0x100; dcache acks 2 cycles later with rdata 0xDEADBEEF.
  - Required: `arb2dcache_w_en` = 0.
  - Required: `arb2lsu_ack` pulses with rdata 0xDEADBEEF.
  - Required: `arb2stb_ack` stays 0.
- **Simultaneous, no hazard:** load at 0x100 and store at 0x200 (wdata 0x11223344, sel 4'b0011).
  - Required: the load is served first.
  - Required: the store is issued with exact wdata/sel one cycle after the load ack.
- **Hazard:** load at 0x104 and store at 0x106 (same word).
  - Required: the store is granted first, then the load.
- **Starvation (macro on, STARVE_LIMIT = 2):** store held continuously while four loads are requested back-to-back.
  - Required: the 3rd grant is the store.
  - Macro off: all four loads are served before the store.
- **Stray ack:** `dcache2arb_ack` pulsed in IDLE.
  - Required: no requester ack, state remains IDLE.
- **Reset mid-transaction:** `rst_n` asserted in STORE_BUSY.
  - Required: `arb2dcache_req` drops to 0 immediately (async).
  - Required: after release, the still-pending store is re-granted.

Source files
------------

// File: rtl/dcache_arb_pkg.sv
// Shared types for the dcache request arbiter: FSM state encoding and the
// registered request bundle presented to the dcache port.
package dcache_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_BUSY,
    STORE_BUSY
  } arb_state_e;

  // Field widths are fixed here, so the arbiter parameters must match them
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_SEL_W-1:0]  sel_byte;
    logic                  w_en;
  } dcache_req_t;

endpackage

// File: rtl/dcache_req_arbiter.sv
// Merges LSU loads and store-buffer drains onto the single dcache port; loads win
// unless the store targets the same word. Define ARB_STARVE_GUARD_EN to bound store starvation.
module dcache_req_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ARB_ADDR_W,
  parameter int unsigned DATA_WIDTH     = ARB_DATA_W,
  parameter int unsigned BYTE_SEL_WIDTH = ARB_SEL_W,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     lsu2arb_addr,
  input  logic                      lsu2arb_req,
  output logic [DATA_WIDTH-1:0]     arb2lsu_rdata,
  output logic                      arb2lsu_ack,
  input  logic [ADDR_WIDTH-1:0]     stb2arb_addr,
  input  logic [DATA_WIDTH-1:0]     stb2arb_wdata,
  input  logic [BYTE_SEL_WIDTH-1:0] stb2arb_sel_byte,
  input  logic                      stb2arb_req,
  output logic                      arb2stb_ack,
  output logic [ADDR_WIDTH-1:0]     arb2dcache_addr,
  output logic [DATA_WIDTH-1:0]     arb2dcache_wdata,
  output logic [BYTE_SEL_WIDTH-1:0] arb2dcache_sel_byte,
  output logic                      arb2dcache_w_en,
  output logic                      arb2dcache_req,
  input  logic [DATA_WIDTH-1:0]     dcache2arb_rdata,
  input  logic                      dcache2arb_ack
);

  localparam int unsigned WORD_OFF = $clog2(BYTE_SEL_WIDTH);

  arb_state_e  state;
  dcache_req_t req_q;
  dcache_req_t load_req;
  dcache_req_t store_req;
  logic        hazard;
  logic        starve;
  logic        any_req;
  logic        grant_store;

  // Same-word hazard: the store must drain first or the load would see stale data
  assign hazard      = (lsu2arb_addr[ADDR_WIDTH-1:WORD_OFF] == stb2arb_addr[ADDR_WIDTH-1:WORD_OFF]);
  assign any_req     = lsu2arb_req | stb2arb_req;
  assign grant_store = stb2arb_req & (~lsu2arb_req | hazard | starve);

  assign load_req  = '{addr: lsu2arb_addr, wdata: '0, sel_byte: '1, w_en: 1'b0};
  assign store_req = '{addr: stb2arb_addr, wdata: stb2arb_wdata,
                       sel_byte: stb2arb_sel_byte, w_en: 1'b1};

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign starve = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts loads that overtook a waiting store; saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (grant_store) begin
        starve_cnt <= '0;
      end else if (stb2arb_req && !starve) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_q          <= '0;
      arb2dcache_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            req_q          <= grant_store ? store_req : load_req;
            arb2dcache_req <= 1'b1;
            state          <= grant_store ? STORE_BUSY : LOAD_BUSY;
          end
        end
        LOAD_BUSY, STORE_BUSY: begin
          if (dcache2arb_ack) begin
            arb2dcache_req <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          state          <= IDLE;
          arb2dcache_req <= 1'b0;
        end
      endcase
    end
  end

  assign arb2dcache_addr     = req_q.addr;
  assign arb2dcache_wdata    = req_q.wdata;
  assign arb2dcache_sel_byte = req_q.sel_byte;
  assign arb2dcache_w_en     = req_q.w_en;

  // Completion is steered to whichever requester owns the in-flight access
  assign arb2lsu_ack   = dcache2arb_ack & (state == LOAD_BUSY);
  assign arb2stb_ack   = dcache2arb_ack & (state == STORE_BUSY);
  assign arb2lsu_rdata = (state == LOAD_BUSY) ? dcache2arb_rdata : '0;

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Self-checking bench for dcache_req_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared against a transaction-level model.
module tb_dcache_req_arbiter;

  localparam int unsigned LIMIT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lsu_addr;
  logic        lsu_req;
  logic [31:0] lsu_rdata;
  logic        lsu_ack;
  logic [31:0] stb_addr;
  logic [31:0] stb_wdata;
  logic [3:0]  stb_sel;
  logic        stb_req;
  logic        stb_ack;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic [3:0]  dc_sel;
  logic        dc_w_en;
  logic        dc_req;
  logic [31:0] dc_rdata;
  logic        dc_ack;

  int checks = 0;
  int failures = 0;

  dcache_req_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_SEL_WIDTH(4), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu2arb_addr(lsu_addr), .lsu2arb_req(lsu_req),
    .arb2lsu_rdata(lsu_rdata), .arb2lsu_ack(lsu_ack),
    .stb2arb_addr(stb_addr), .stb2arb_wdata(stb_wdata),
    .stb2arb_sel_byte(stb_sel), .stb2arb_req(stb_req), .arb2stb_ack(stb_ack),
    .arb2dcache_addr(dc_addr), .arb2dcache_wdata(dc_wdata),
    .arb2dcache_sel_byte(dc_sel), .arb2dcache_w_en(dc_w_en),
    .arb2dcache_req(dc_req), .dcache2arb_rdata(dc_rdata), .dcache2arb_ack(dc_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the port and what was issued
  bit          m_busy;
  bit          m_store;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_sel;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    bit store_wins;
    if (!rst_n) begin
      m_busy  = 0;
      m_store = 0;
      m_cnt   = 0;
    end else if (m_busy) begin
      if (dc_ack) m_busy = 0;
    end else if (lsu_req || stb_req) begin
      store_wins = stb_req && (!lsu_req || (lsu_addr / 4) == (stb_addr / 4));
`ifdef ARB_STARVE_GUARD_EN
      if (stb_req && lsu_req && m_cnt == LIMIT) store_wins = 1;
`endif
      m_busy  = 1;
      m_store = store_wins;
      if (store_wins) begin
        m_addr  = stb_addr;
        m_wdata = stb_wdata;
        m_sel   = stb_sel;
        m_cnt   = 0;
      end else begin
        m_addr  = lsu_addr;
        m_wdata = 32'h0;
        m_sel   = 4'hF;
        if (stb_req && m_cnt < LIMIT) m_cnt = m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    checkOutput("req_valid", dc_req, m_busy);
    checkOutput("lsu_ack", lsu_ack, dc_ack && m_busy && !m_store);
    checkOutput("stb_ack", stb_ack, dc_ack && m_busy && m_store);
    checkOutput("lsu_rdata", lsu_rdata, (m_busy && !m_store) ? dc_rdata : 32'h0);
    if (m_busy) begin
      checkOutput("req_addr", dc_addr, m_addr);
      checkOutput("req_w_en", dc_w_en, m_store);
      checkOutput("req_wdata", dc_wdata, m_wdata);
      checkOutput("req_sel", dc_sel, m_sel);
    end
  end

  task automatic waitGrant();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = dc_req;
    end
    if (!seen) checkOutput("grant_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [31:0] rd);
    @(negedge clk);
    dc_ack   = 1'b1;
    dc_rdata = rd;
    #1;
  endtask

  task automatic endAck();
    @(negedge clk);
    dc_ack = 1'b0;
  endtask

  bit          order[5];
  bit          exp_order[5];
  int          loads_done;
  int          lat;
  bit          in_tx;
  bit          lsu_got;
  bit          stb_got;

  initial begin
    rst_n = 0; lsu_addr = 0; lsu_req = 0; stb_addr = 0; stb_wdata = 0;
    stb_sel = 0; stb_req = 0; dc_rdata = 0; dc_ack = 0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req", dc_req, 0);
    checkOutput("rst_addr", dc_addr, 0);
    checkOutput("rst_w_en", dc_w_en, 0);
    checkOutput("rst_lsu_ack", lsu_ack, 0);
    @(negedge clk);
    rst_n = 1;

    // Load only
    @(negedge clk);
    lsu_addr = 32'h100; lsu_req = 1;
    waitGrant();
    checkOutput("ld_addr", dc_addr, 32'h100);
    checkOutput("ld_w_en", dc_w_en, 0);
    checkOutput("ld_sel", dc_sel, 4'hF);
    @(negedge clk);
    applyStimulus(32'hDEADBEEF);
    checkOutput("ld_ack", lsu_ack, 1);
    checkOutput("ld_rdata", lsu_rdata, 32'hDEADBEEF);
    checkOutput("ld_stb_ack", stb_ack, 0);
    lsu_req = 0;
    endAck();

    // Simultaneous, no hazard
    lsu_addr = 32'h100; lsu_req = 1;
    stb_addr = 32'h200; stb_wdata = 32'h11223344; stb_sel = 4'b0011; stb_req = 1;
    waitGrant();
    checkOutput("sim_first_w_en", dc_w_en, 0);
    checkOutput("sim_first_addr", dc_addr, 32'h100);
    applyStimulus(32'h55);
    lsu_req = 0;
    endAck();
    #1;
    checkOutput("sim_gap_req", dc_req, 0);
    @(negedge clk);
    #1;
    checkOutput("sim_st_req", dc_req, 1);
    checkOutput("sim_st_addr", dc_addr, 32'h200);
    checkOutput("sim_st_wdata", dc_wdata, 32'h11223344);
    checkOutput("sim_st_sel", dc_sel, 4'b0011);
    checkOutput("sim_st_w_en", dc_w_en, 1);
    applyStimulus(32'h0);
    checkOutput("sim_st_ack", stb_ack, 1);
    stb_req = 0;
    endAck();

    // Same-word hazard
    lsu_addr = 32'h104; lsu_req = 1;
    stb_addr = 32'h106; stb_wdata = 32'hA5A5A5A5; stb_sel = 4'b1100; stb_req = 1;
    waitGrant();
    checkOutput("hz_first_w_en", dc_w_en, 1);
    checkOutput("hz_first_addr", dc_addr, 32'h106);
    applyStimulus(32'h0);
    stb_req = 0;
    endAck();
    waitGrant();
    checkOutput("hz_second_w_en", dc_w_en, 0);
    checkOutput("hz_second_addr", dc_addr, 32'h104);
    applyStimulus(32'h77);
    lsu_req = 0;
    endAck();

    // Starvation: store held while four loads arrive back-to-back
`ifdef ARB_STARVE_GUARD_EN
    exp_order = '{0, 0, 1, 0, 0};
`else
    exp_order = '{0, 0, 0, 0, 1};
`endif
    loads_done = 0;
    lsu_addr = 32'h10; lsu_req = 1;
    stb_addr = 32'h400; stb_wdata = 32'hCAFEF00D; stb_sel = 4'hF; stb_req = 1;
    for (int g = 0; g < 5; g++) begin
      waitGrant();
      order[g] = dc_w_en;
      applyStimulus($urandom);
      if (dc_w_en) begin
        stb_req = 0;
      end else begin
        loads_done++;
        if (loads_done == 4) lsu_req = 0;
        else lsu_addr = lsu_addr + 32'h10;
      end
      endAck();
    end
    for (int g = 0; g < 5; g++) checkOutput($sformatf("starve_grant%0d", g), order[g], exp_order[g]);
    lsu_req = 0; stb_req = 0;

    // Stray ack in IDLE
    @(negedge clk);
    applyStimulus(32'h1234);
    checkOutput("stray_lsu_ack", lsu_ack, 0);
    checkOutput("stray_stb_ack", stb_ack, 0);
    endAck();
    #1;
    checkOutput("stray_idle", dc_req, 0);

    // Reset mid-transaction
    stb_addr = 32'h300; stb_wdata = 32'h0BADF00D; stb_sel = 4'b0110; stb_req = 1;
    waitGrant();
    checkOutput("rmt_w_en", dc_w_en, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    checkOutput("rmt_async_drop", dc_req, 0);
    @(negedge clk);
    rst_n = 1;
    waitGrant();
    checkOutput("rmt_regrant_addr", dc_addr, 32'h300);
    checkOutput("rmt_regrant_w_en", dc_w_en, 1);
    applyStimulus(32'h0);
    checkOutput("rmt_stb_ack", stb_ack, 1);
    stb_req = 0;
    endAck();

    // Randomized traffic with word-colliding addresses and random dcache latency
    in_tx = 0; lat = 0; lsu_got = 0; stb_got = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      dc_ack = 1'b0;
      if (dc_req) begin
        if (!in_tx) begin
          in_tx = 1;
          lat = $urandom_range(0, 3);
        end
        if (lat == 0) begin
          dc_ack = 1'b1;
          dc_rdata = $urandom;
          in_tx = 0;
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        dc_ack = 1'b1;
        dc_rdata = $urandom;
      end
      if (lsu_got) begin
        lsu_req = $urandom_range(0, 1);
        lsu_addr = $urandom_range(0, 31);
      end else if (!lsu_req && $urandom_range(0, 2) == 0) begin
        lsu_req = 1;
        lsu_addr = $urandom_range(0, 31);
      end else if (lsu_req && $urandom_range(0, 31) == 0) begin
        lsu_req = 0;
      end
      if (stb_got) begin
        stb_req = $urandom_range(0, 1);
        stb_addr = $urandom_range(0, 31);
        stb_wdata = $urandom;
        stb_sel = 4'($urandom_range(1, 15));
      end else if (!stb_req && $urandom_range(0, 1) == 0) begin
        stb_req = 1;
        stb_addr = $urandom_range(0, 31);
        stb_wdata = $urandom;
        stb_sel = 4'($urandom_range(1, 15));
      end
      #1;
      lsu_got = lsu_ack;
      stb_got = stb_ack;
    end
    @(negedge clk);
    dc_ack = 0; lsu_req = 0; stb_req = 0;
    repeat (2) @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
